// File: rtl/sync_array_filter.sv
// sync_array_filter: multi-channel level synchroniser with per-channel glitch filter
// and registered rise/fall strobes.
// Optional event counter enabled by defining SYNC_ARRAY_FILTER_EVENT_CNT_EN; when the
// macro is undefined event_cnt is tied to zero and cnt_clr is ignored.
module sync_array_filter #(
    parameter int unsigned      WIDTH         = 8,
    parameter int unsigned      SYNC_STAGES   = 3,
    parameter int unsigned      FILTER_CYCLES = 4,
    parameter logic [WIDTH-1:0] INIT_VAL      = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] async_in,
    input  logic             filt_en,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] filt_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             any_event,
    input  logic             cnt_clr,
    output logic [15:0]      event_cnt
);

    localparam int unsigned CNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES - 1);

    logic [WIDTH-1:0] stage_q [SYNC_STAGES];
    logic [WIDTH-1:0] stage_d [SYNC_STAGES];
    logic [CNT_W-1:0] cnt_q   [WIDTH];
    logic [CNT_W-1:0] cnt_d   [WIDTH];
    logic [WIDTH-1:0] filt_q, filt_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic             any_event_q, any_event_d;

    assign sync_out   = stage_q[SYNC_STAGES-1];
    assign filt_out   = filt_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign any_event  = any_event_q;

    // Synchroniser chain shifts every cycle, independent of filt_en.
    always_comb begin
        stage_d[0] = async_in;
        for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
            stage_d[k] = stage_q[k-1];
        end
    end

    // Stability filter: accept a new level only after FILTER_CYCLES of disagreement.
    always_comb begin
        filt_d = filt_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (!filt_en) begin
                filt_d[i] = sync_out[i];
            end else if (sync_out[i] == filt_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                filt_d[i] = sync_out[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
        // Strobes are registered alongside filt_q so they align with the new level.
        rise_d      = ~filt_q & filt_d;
        fall_d      = filt_q & ~filt_d;
        any_event_d = |(rise_d | fall_d);
    end

    // State registers for sync chain, filter, counters and strobes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
                stage_q[k] <= INIT_VAL;
            end
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            filt_q      <= INIT_VAL;
            rise_q      <= '0;
            fall_q      <= '0;
            any_event_q <= 1'b0;
        end else begin
            for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
                stage_q[k] <= stage_d[k];
            end
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            filt_q      <= filt_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            any_event_q <= any_event_d;
        end
    end

`ifdef SYNC_ARRAY_FILTER_EVENT_CNT_EN
    logic [15:0] event_cnt_q, event_cnt_d;

    // Saturating event counter; clear takes priority over increment.
    always_comb begin
        event_cnt_d = event_cnt_q;
        if (cnt_clr) begin
            event_cnt_d = '0;
        end else if (any_event_q && (event_cnt_q != 16'hFFFF)) begin
            event_cnt_d = event_cnt_q + 16'd1;
        end
    end

    // Event counter register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            event_cnt_q <= '0;
        end else begin
            event_cnt_q <= event_cnt_d;
        end
    end

    assign event_cnt = event_cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign event_cnt      = 16'h0000;
`endif

endmodule

// File: tb/tb_sync_array_filter.sv
// Directed, table-driven bench for sync_array_filter (WIDTH=4, 3 stages, filter 4).
module tb_sync_array_filter;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  async_in;
    logic        filt_en;
    logic        cnt_clr;
    logic [3:0]  sync_out, filt_out, rise_pulse, fall_pulse;
    logic        any_event;
    logic [15:0] event_cnt;

    int total = 0;
    int bad   = 0;

    sync_array_filter #(
        .WIDTH        (4),
        .SYNC_STAGES  (3),
        .FILTER_CYCLES(4),
        .INIT_VAL     (4'b0000)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .async_in  (async_in),
        .filt_en   (filt_en),
        .sync_out  (sync_out),
        .filt_out  (filt_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .any_event (any_event),
        .cnt_clr   (cnt_clr),
        .event_cnt (event_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] ain;
        logic       fen;
        int         n;     // edges to advance before checking
        logic [3:0] sync;
        logic [3:0] filt;
        logic [3:0] rise;
        logic [3:0] fall;
        logic       any;
    } vec_t;

    vec_t tbl [30];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %h want %h", nm, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input logic [3:0] s, input logic [3:0] f,
                           input logic [3:0] r, input logic [3:0] fl, input logic a);
        chk("sync_out", idx, 16'(sync_out), 16'(s));
        chk("filt_out", idx, 16'(filt_out), 16'(f));
        chk("rise_pulse", idx, 16'(rise_pulse), 16'(r));
        chk("fall_pulse", idx, 16'(fall_pulse), 16'(fl));
        chk("any_event", idx, 16'(any_event), 16'(a));
    endtask

    initial begin
        tbl = '{
            // release with all inputs high: sync after 3 edges, filt after 7
            '{4'hF, 1'b1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0},
            '{4'hF, 1'b1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0},
            '{4'hF, 1'b1, 1, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0},
            '{4'hF, 1'b1, 3, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0},
            '{4'hF, 1'b1, 1, 4'hF, 4'hF, 4'hF, 4'h0, 1'b1},
            '{4'hF, 1'b1, 1, 4'hF, 4'hF, 4'h0, 4'h0, 1'b0},
            // return all channels to 0
            '{4'h0, 1'b1, 3, 4'h0, 4'hF, 4'h0, 4'h0, 1'b0},
            '{4'h0, 1'b1, 3, 4'h0, 4'hF, 4'h0, 4'h0, 1'b0},
            '{4'h0, 1'b1, 1, 4'h0, 4'h0, 4'h0, 4'hF, 1'b1},
            '{4'h0, 1'b1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0},
            // two 3-cycle glitches on ch1 separated by one agreeing cycle
            '{4'h2, 1'b1, 3, 4'h2, 4'h0, 4'h0, 4'h0, 1'b0},
            '{4'h0, 1'b1, 1, 4'h2, 4'h0, 4'h0, 4'h0, 1'b0},
            '{4'h2, 1'b1, 3, 4'h2, 4'h0, 4'h0, 4'h0, 1'b0},
            '{4'h0, 1'b1, 2, 4'h2, 4'h0, 4'h0, 4'h0, 1'b0},
            '{4'h0, 1'b1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0},
            '{4'h0, 1'b1, 3, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0},
            // 4-cycle pulse on ch1 is accepted, high for 4 cycles
            '{4'h2, 1'b1, 4, 4'h2, 4'h0, 4'h0, 4'h0, 1'b0},
            '{4'h0, 1'b1, 3, 4'h0, 4'h2, 4'h2, 4'h0, 1'b1},
            '{4'h0, 1'b1, 1, 4'h0, 4'h2, 4'h0, 4'h0, 1'b0},
            '{4'h0, 1'b1, 2, 4'h0, 4'h2, 4'h0, 4'h0, 1'b0},
            '{4'h0, 1'b1, 1, 4'h0, 4'h0, 4'h0, 4'h2, 1'b1},
            '{4'h0, 1'b1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0},
            // bypass: filt follows sync one edge later
            '{4'h5, 1'b0, 3, 4'h5, 4'h0, 4'h0, 4'h0, 1'b0},
            '{4'h5, 1'b0, 1, 4'h5, 4'h5, 4'h5, 4'h0, 1'b1},
            '{4'hA, 1'b0, 3, 4'hA, 4'h5, 4'h0, 4'h0, 1'b0},
            '{4'hA, 1'b0, 1, 4'hA, 4'hA, 4'hA, 4'h5, 1'b1},
            '{4'hA, 1'b0, 1, 4'hA, 4'hA, 4'h0, 4'h0, 1'b0},
            // partial count then filt_en 1->0 updates at the next edge
            '{4'h0, 1'b1, 5, 4'h0, 4'hA, 4'h0, 4'h0, 1'b0},
            '{4'h0, 1'b0, 1, 4'h0, 4'h0, 4'h0, 4'hA, 1'b1},
            '{4'h0, 1'b0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0}
        };

        rstn     = 1'b0;
        async_in = 4'hF;
        filt_en  = 1'b1;
        cnt_clr  = 1'b0;
        step(2);
        chk_all(-1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        chk("event_cnt_rst", -1, event_cnt, 16'h0000);
        rstn = 1'b1;

        for (int i = 0; i < 30; i++) begin
            async_in = tbl[i].ain;
            filt_en  = tbl[i].fen;
            cnt_clr  = i[0];
            step(tbl[i].n);
            chk_all(i, tbl[i].sync, tbl[i].filt, tbl[i].rise, tbl[i].fall, tbl[i].any);
`ifndef SYNC_ARRAY_FILTER_EVENT_CNT_EN
            chk("event_cnt_tied", i, event_cnt, 16'h0000);
`endif
        end

        // reset mid-count on ch0 (cnt=2), then full latency after release
        cnt_clr  = 1'b0;
        filt_en  = 1'b1;
        async_in = 4'h1;
        step(5);
        chk_all(100, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0);
        rstn = 1'b0;
        #1;
        chk_all(101, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        step(1);
        rstn = 1'b1;
        for (int r = 1; r <= 8; r++) begin
            step(1);
            chk_all(110 + r, (r >= 3) ? 4'h1 : 4'h0, (r >= 7) ? 4'h1 : 4'h0,
                    (r == 7) ? 4'h1 : 4'h0, 4'h0, (r == 7));
        end

`ifdef SYNC_ARRAY_FILTER_EVENT_CNT_EN
        cnt_clr = 1'b1;
        step(1);
        chk("event_cnt_clr", 200, event_cnt, 16'h0000);
        cnt_clr = 1'b0;
        filt_en = 1'b0;
        // toggling ch0 in bypass yields an event every cycle once the pipe fills
        for (int c = 0; c < 70010; c++) begin
            async_in = {3'b000, ~async_in[0]};
            step(1);
        end
        chk("any_event_busy", 201, 16'(any_event), 16'h0001);
        chk("event_cnt_sat", 202, event_cnt, 16'hFFFF);
        cnt_clr  = 1'b1;
        async_in = {3'b000, ~async_in[0]};
        step(1);
        chk("event_cnt_clr_wins", 203, event_cnt, 16'h0000);
        cnt_clr  = 1'b0;
        async_in = {3'b000, ~async_in[0]};
        step(1);
        chk("event_cnt_inc", 204, event_cnt, 16'h0001);
`else
        chk("event_cnt_end", 200, event_cnt, 16'h0000);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
